// File: rtl/motor_pwm_driver_if.sv
// Assistance-to-motor drive bundle: requested duty and brake in, PWM/direction/status out.
// The master side drives the request and brake; the slave side is the PWM driver.
interface motor_pwm_driver_if;
    logic signed [9:0] AssistanceRequirement;
    logic              brake;
    logic              MotorPWM;
    logic              MotorDir;
    logic signed [9:0] AppliedDuty;
    logic              PeriodStart;

    modport master (
        output AssistanceRequirement, brake,
        input  MotorPWM, MotorDir, AppliedDuty, PeriodStart
    );

    modport slave (
        input  AssistanceRequirement, brake,
        output MotorPWM, MotorDir, AppliedDuty, PeriodStart
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// Fixed-frequency PWM motor drive with slew-limited duty, coast dead-time on reversal and fast brake cut.
// Duty and state change only at period boundaries; brake forces zero drive two edges after it is synchronised.
module motor_pwm_driver #(
    parameter int PRESCALE     = 4,
    parameter int SLEW_STEP    = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    motor_pwm_driver_if.slave   bus
);
    localparam int                     PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]          PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic signed [10:0]     STEP      = 11'(SLEW_STEP);
    localparam logic [3:0]             DEAD_LOAD = 4'(DEAD_PERIODS);

    typedef enum logic [1:0] {RUN, DEAD, BRAKE} state_t;

    state_t            state, state_n, run_state;
    logic [PW-1:0]     presc;
    logic [8:0]        phase;
    logic [3:0]        cnt, cnt_n, run_cnt;
    logic              brake_m, brake_s;
    logic signed [9:0] duty, duty_n, run_duty;
    logic              dir, dir_n, run_dir;
    logic              pwm, period_start;
    logic              tick, boundary;
    logic [8:0]        mag;
    logic signed [10:0] t, d, diff;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (phase == 9'd511);
    assign mag      = duty[9] ? 9'(-duty) : duty[8:0];
    assign t        = (bus.AssistanceRequirement == -10'sd512) ? -11'sd511
                                                              : 11'(bus.AssistanceRequirement);
    assign d        = 11'(duty);
    assign diff     = t - d;

    // Regular RUN update, also reused when leaving DEAD or BRAKE at a boundary.
    always_comb begin
        run_state = RUN;
        run_duty  = duty;
        run_dir   = dir;
        run_cnt   = cnt;
        if ((d > 11'sd0 && t < 11'sd0) || (d < 11'sd0 && t > 11'sd0)) begin
            if (d > 11'sd0)
                run_duty = (d > STEP) ? 10'(d - STEP) : 10'sd0;
            else
                run_duty = (-d > STEP) ? 10'(d + STEP) : 10'sd0;
        end else if (d == 11'sd0 && t != 11'sd0 && ((t > 11'sd0) != dir)) begin
            if (DEAD_PERIODS == 0) begin
                run_dir = ~dir;
            end else begin
                run_state = DEAD;
                run_cnt   = DEAD_LOAD;
            end
        end else if (diff <= STEP && diff >= -STEP) begin
            run_duty = t[9:0];
        end else if (diff > 11'sd0) begin
            run_duty = 10'(d + STEP);
        end else begin
            run_duty = 10'(d - STEP);
        end
    end

    always_comb begin
        state_n = state;
        duty_n  = duty;
        dir_n   = dir;
        cnt_n   = cnt;
        if (brake_s) begin
            state_n = BRAKE;
            duty_n  = 10'sd0;
            cnt_n   = 4'd0;
        end else if (boundary) begin
            if (state == DEAD && !(t == 11'sd0 || ((t > 11'sd0) == dir))) begin
                if (cnt == 4'd1) begin
                    dir_n   = ~dir;
                    cnt_n   = 4'd0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end else begin
                state_n = run_state;
                duty_n  = run_duty;
                dir_n   = run_dir;
                cnt_n   = run_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            phase        <= 9'd0;
            brake_m      <= 1'b0;
            brake_s      <= 1'b0;
            state        <= RUN;
            duty         <= 10'sd0;
            dir          <= 1'b1;
            cnt          <= 4'd0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            brake_m      <= bus.brake;
            brake_s      <= brake_m;
            presc        <= tick ? '0 : presc + 1'b1;
            if (tick)
                phase <= phase + 9'd1;
            state        <= state_n;
            duty         <= duty_n;
            dir          <= dir_n;
            cnt          <= cnt_n;
            pwm          <= (phase < mag) && (state == RUN) && !brake_s;
            period_start <= boundary;
        end
    end

    assign bus.MotorPWM    = pwm;
    assign bus.MotorDir    = dir;
    assign bus.AppliedDuty = duty;
    assign bus.PeriodStart = period_start;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench: default-parameter driver through idle, slew, brake, dead-time and reset,
// plus a fast-period instance (no dead-time, full-range slew) exposing the -512 clamp.
module tb_motor_pwm_driver;
    logic clk = 1'b0;
    logic rst_n, rst2_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   waited, pwm_hi;

    always #5 clk = ~clk;

    motor_pwm_driver_if ifc ();
    motor_pwm_driver_if ifc2 ();

    motor_pwm_driver dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    motor_pwm_driver #(.PRESCALE(1), .SLEW_STEP(511), .DEAD_PERIODS(0))
        dut2 (.clk(clk), .rst_n(rst2_n), .bus(ifc2));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_ps(input bit sel, input int budget);
        int n = 0;
        bit seen = 1'b0;
        pwm_hi = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if ((sel ? ifc2.MotorPWM : ifc.MotorPWM) === 1'b1) pwm_hi++;
            seen = ((sel ? ifc2.PeriodStart : ifc.PeriodStart) === 1'b1);
        end
        waited = n;
        chk("period_start_seen", 32'(seen), 1);
    endtask

    task automatic step(input bit sel, input string tag, input int exp_duty, input int exp_dir);
        wait_ps(sel, sel ? 600 : 2100);
        chk({tag, "_duty"}, sel ? ifc2.AppliedDuty : ifc.AppliedDuty, exp_duty);
        chk({tag, "_dir"},  sel ? ifc2.MotorDir : ifc.MotorDir, exp_dir);
    endtask

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        ifc.AssistanceRequirement  = 10'sd0;
        ifc.brake                  = 1'b0;
        ifc2.AssistanceRequirement = 10'sd0;
        ifc2.brake                 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", ifc.MotorPWM, 0);
        chk("rst_dir", ifc.MotorDir, 1);
        chk("rst_duty", ifc.AppliedDuty, 0);
        chk("rst_ps", ifc.PeriodStart, 0);
        rst_n = 1'b1;

        // Idle: first boundary a full period after release, then periodic.
        wait_ps(0, 2100);
        chk("idle_first_ps", waited, 2048);
        chk("idle_pwm", pwm_hi, 0);
        chk("idle_duty", ifc.AppliedDuty, 0);
        chk("idle_dir", ifc.MotorDir, 1);
        wait_ps(0, 2100);
        chk("idle_period", waited, 2048);
        chk("idle_pwm2", pwm_hi, 0);

        // Forward step: 8,16,...,96 then 100.
        ifc.AssistanceRequirement = 10'sd100;
        for (int k = 1; k <= 13; k++)
            step(0, "fwd", (8 * k < 100) ? 8 * k : 100, 1);
        wait_ps(0, 2100);
        chk("fwd_period", waited, 2048);
        chk("fwd_high_time", pwm_hi, 400);
        chk("fwd_hold", ifc.AppliedDuty, 100);

        // Brake at phase 50 of a d=100 period.
        repeat (200) @(negedge clk);
        chk("brk_pre_pwm", ifc.MotorPWM, 1);
        ifc.brake = 1'b1;
        repeat (2) @(negedge clk);
        chk("brk_sync_pwm", ifc.MotorPWM, 1);
        @(negedge clk);
        chk("brk_pwm", ifc.MotorPWM, 0);
        chk("brk_duty", ifc.AppliedDuty, 0);
        chk("brk_dir", ifc.MotorDir, 1);
        repeat (400) @(negedge clk);
        ifc.brake = 1'b0;
        repeat (100) @(negedge clk);
        chk("brk_rel_duty", ifc.AppliedDuty, 0);
        chk("brk_rel_pwm", ifc.MotorPWM, 0);
        step(0, "brk_exit", 8, 1);
        chk("brk_exit_pwm", pwm_hi, 0);

        // Dead-time abort: target returns to forward while counting.
        ifc.AssistanceRequirement = -10'sd100;
        step(0, "abort_dn", 0, 1);
        step(0, "abort_dead", 0, 1);
        ifc.AssistanceRequirement = 10'sd50;
        step(0, "abort_run", 8, 1);
        chk("abort_dead_pwm", pwm_hi, 0);

        // Reversal from d=20 with the -512 request.
        ifc.AssistanceRequirement = 10'sd20;
        step(0, "rev_set1", 16, 1);
        step(0, "rev_set2", 20, 1);
        ifc.AssistanceRequirement = -10'sd512;
        step(0, "rev_dn1", 12, 1);
        step(0, "rev_dn2", 4, 1);
        step(0, "rev_dn3", 0, 1);
        step(0, "rev_dead1", 0, 1);
        step(0, "rev_dead2", 0, 1);
        chk("rev_dead_pwm", pwm_hi, 0);
        step(0, "rev_flip", 0, 0);
        chk("rev_flip_pwm", pwm_hi, 0);
        step(0, "rev_up1", -8, 0);
        step(0, "rev_up2", -16, 0);
        chk("rev_neg_high_time", pwm_hi, 32);

        // Asynchronous reset in the middle of a period.
        repeat (40) @(negedge clk);
        chk("rstmid_pre_pwm", ifc.MotorPWM, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_pwm", ifc.MotorPWM, 0);
        chk("rstmid_dir", ifc.MotorDir, 1);
        chk("rstmid_duty", ifc.AppliedDuty, 0);
        chk("rstmid_ps", ifc.PeriodStart, 0);
        ifc.AssistanceRequirement = 10'sd0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps(0, 2100);
        chk("rstmid_first_ps", waited, 2048);
        chk("rstmid_idle_pwm", pwm_hi, 0);
        chk("rstmid_idle_duty", ifc.AppliedDuty, 0);
        chk("rstmid_idle_dir", ifc.MotorDir, 1);

        // Fast instance: immediate flip, full swing in one step, -512 clamped to -511.
        ifc2.AssistanceRequirement = -10'sd512;
        @(negedge clk);
        rst2_n = 1'b1;
        step(1, "z_flip", 0, 0);
        chk("z_period", waited, 512);
        step(1, "z_full", -511, 0);
        step(1, "z_clamp", -511, 0);
        chk("z_high_time", pwm_hi, 511);
        ifc2.AssistanceRequirement = 10'sd511;
        step(1, "z_back", 0, 0);
        step(1, "z_flip2", 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
